// File: rtl/des_iter_ctrl.sv
// Iterative DES engine controller: ROUNDS_PER_CYCLE Feistel rounds per clock with an
// on-the-fly PC1/rotate/PC2 subkey schedule, encrypt or decrypt per block.
module des_iter_ctrl #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        decrypt,
  input  logic [63:0] key,
  input  logic [63:0] data_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] data_out,
  output logic        busy
);
  localparam int RPC = ROUNDS_PER_CYCLE;

  // Tables list FIPS bit numbers (1 = MSB of the source vector).
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  // One 64-bit word per S-box row, column 0 in the top nibble; S1 rows first.
  localparam logic [63:0] SBOX_ROWS [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[6'(63-i)] = x[6'(64-IP_T[i])];
    return o;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[6'(63-i)] = x[6'(64-FP_T[i])];
    return o;
  endfunction

  function automatic logic [47:0] expand(input logic [31:0] x);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[6'(47-i)] = x[5'(32-E_T[i])];
    return o;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] o;
    for (int i = 0; i < 32; i++) o[5'(31-i)] = x[5'(32-P_T[i])];
    return o;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] x);
    logic [55:0] o;
    for (int i = 0; i < 56; i++) o[6'(55-i)] = x[6'(64-PC1_T[i])];
    return o;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] x);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[6'(47-i)] = x[6'(56-PC2_T[i])];
    return o;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [5:0]  b;
    logic [63:0] row;
    x = expand(r) ^ k;
    for (int i = 0; i < 8; i++) begin
      b   = x[6'(6*i) +: 6];
      row = SBOX_ROWS[5'((7-i)*4 + int'({b[5], b[0]}))];
      s[5'(4*i) +: 4] = row[6'(60 - 4*int'(b[4:1])) +: 4];
    end
    return perm_p(s);
  endfunction

  function automatic logic shift_two(input int r);
    return !(r == 0 || r == 1 || r == 8 || r == 15);
  endfunction

  // Decrypt walks the schedule backwards: round 0 reuses C0/D0 (== C16/D16).
  function automatic logic [55:0] key_next(input logic [55:0] cd, input logic dec, input int r);
    logic [27:0] c, d;
    logic        two;
    c   = cd[55:28];
    d   = cd[27:0];
    two = 1'b0;
    if (!dec) begin
      two = shift_two(r);
      c = two ? {c[25:0], c[27:26]} : {c[26:0], c[27]};
      d = two ? {d[25:0], d[27:26]} : {d[26:0], d[27]};
    end else if (r != 0) begin
      two = shift_two(16 - r);
      c = two ? {c[1:0], c[27:2]} : {c[0], c[27:1]};
      d = two ? {d[1:0], d[27:2]} : {d[0], d[27:1]};
    end
    return {c, d};
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  rcnt_q, rcnt_d;
  logic        dec_q, dec_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [55:0] cd_q, cd_d;
  logic [63:0] dout_q, dout_d;
  logic [31:0] l_ch [RPC+1];
  logic [31:0] r_ch [RPC+1];
  logic [55:0] cd_ch [RPC+1];

  always_comb begin
    l_ch[0]  = l_q;
    r_ch[0]  = r_q;
    cd_ch[0] = cd_q;
    for (int j = 0; j < RPC; j++) begin
      cd_ch[j+1] = key_next(cd_ch[j], dec_q, int'(rcnt_q) + j);
      l_ch[j+1]  = r_ch[j];
      r_ch[j+1]  = l_ch[j] ^ feistel(r_ch[j], pc2(cd_ch[j+1]));
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    dec_d   = dec_q;
    l_d     = l_q;
    r_d     = r_q;
    cd_d    = cd_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: if (in_valid) begin
        {l_d, r_d} = perm_ip(data_in);
        cd_d       = pc1(key);
        dec_d      = decrypt;
        rcnt_d     = '0;
        state_d    = ROUND;
      end
      ROUND: begin
        l_d    = l_ch[RPC];
        r_d    = r_ch[RPC];
        cd_d   = cd_ch[RPC];
        rcnt_d = rcnt_q + 5'(RPC);
        if (int'(rcnt_q) + RPC == 16) begin
          dout_d  = perm_fp({r_ch[RPC], l_ch[RPC]});
          state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      dout_q  <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    l_q   <= l_d;
    r_q   <= r_d;
    cd_q  <= cd_d;
    dec_q <= dec_d;
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign data_out  = dout_q;
endmodule

// File: tb/tb_des_iter_ctrl.sv
// Directed bench for des_iter_ctrl: FIPS vectors, latency per ROUNDS_PER_CYCLE,
// backpressure, mid-flight reset and back-to-back blocks with key changes.
`timescale 1ns/1ps
module tb_des_iter_ctrl;
  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT = 64'h85E813540F0AB405;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] P2 = 64'h8787878787878787;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, decrypt, out_ready, in_ready, out_valid, busy;
  logic [63:0] key, data_in, data_out;
  logic        in_valid_x, out_ready_x;
  logic        in_ready_x [3];
  logic        out_valid_x [3];
  logic        busy_x [3];
  logic [63:0] data_out_x [3];
  int n_tests = 0;
  int n_fail  = 0;

  des_iter_ctrl #(.ROUNDS_PER_CYCLE(1)) u_r1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .decrypt(decrypt),
    .key(key), .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .busy(busy));
  des_iter_ctrl #(.ROUNDS_PER_CYCLE(2)) u_r2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_x), .in_ready(in_ready_x[0]), .decrypt(decrypt),
    .key(key), .data_in(data_in), .out_valid(out_valid_x[0]), .out_ready(out_ready_x),
    .data_out(data_out_x[0]), .busy(busy_x[0]));
  des_iter_ctrl #(.ROUNDS_PER_CYCLE(4)) u_r4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_x), .in_ready(in_ready_x[1]), .decrypt(decrypt),
    .key(key), .data_in(data_in), .out_valid(out_valid_x[1]), .out_ready(out_ready_x),
    .data_out(data_out_x[1]), .busy(busy_x[1]));
  des_iter_ctrl #(.ROUNDS_PER_CYCLE(16)) u_r16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_x), .in_ready(in_ready_x[2]), .decrypt(decrypt),
    .key(key), .data_in(data_in), .out_valid(out_valid_x[2]), .out_ready(out_ready_x),
    .data_out(data_out_x[2]), .busy(busy_x[2]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic ov(input int i);
    case (i)
      0: return out_valid;
      1: return out_valid_x[0];
      2: return out_valid_x[1];
      default: return out_valid_x[2];
    endcase
  endfunction

  function automatic logic [63:0] dout(input int i);
    case (i)
      0: return data_out;
      1: return data_out_x[0];
      2: return data_out_x[1];
      default: return data_out_x[2];
    endcase
  endfunction

  // Single block through the R=1 engine; inputs are scrambled right after accept.
  task automatic run_one(input string tag, input logic [63:0] k, input logic [63:0] d,
                         input logic dec, input logic [63:0] exp);
    int lat;
    chk1({tag, "_in_ready"}, in_ready, 1'b1);
    key = k; data_in = d; decrypt = dec; in_valid = 1'b1;
    step();
    in_valid = 1'b0; key = ~k; data_in = ~d; decrypt = ~dec;
    chk1({tag, "_busy"}, busy, 1'b1);
    chk1({tag, "_no_ready"}, in_ready, 1'b0);
    lat = 1;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    chki({tag, "_latency"}, lat, 17);
    chk64({tag, "_data"}, data_out, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk1({tag, "_ov_clr"}, out_valid, 1'b0);
    chk1({tag, "_idle"}, in_ready, 1'b1);
  endtask

  // Same block into all four engines at once; latency measured from the accept cycle.
  task automatic run_all(input string tag, input logic [63:0] k, input logic [63:0] d,
                         input logic dec, input logic [63:0] exp);
    int lat [4];
    int rs [4];
    rs = '{1, 2, 4, 16};
    for (int i = 0; i < 4; i++) lat[i] = 0;
    for (int i = 0; i < 3; i++) chk1($sformatf("%s_in_ready_x%0d", tag, i), in_ready_x[i], 1'b1);
    key = k; data_in = d; decrypt = dec; in_valid = 1'b1; in_valid_x = 1'b1;
    step();
    in_valid = 1'b0; in_valid_x = 1'b0; key = ~k; data_in = ~d; decrypt = ~dec;
    for (int i = 0; i < 3; i++) chk1($sformatf("%s_busy_x%0d", tag, i), busy_x[i], 1'b1);
    for (int c = 2; c <= 24; c++) begin
      step();
      for (int i = 0; i < 4; i++) if (lat[i] == 0 && ov(i)) lat[i] = c;
    end
    for (int i = 0; i < 4; i++) begin
      chki($sformatf("%s_lat_r%0d", tag, rs[i]), lat[i], 16 / rs[i] + 1);
      chk64($sformatf("%s_data_r%0d", tag, rs[i]), dout(i), exp);
    end
    out_ready = 1'b1; out_ready_x = 1'b1;
    step();
    out_ready = 1'b0; out_ready_x = 1'b0;
    for (int i = 0; i < 4; i++) chk1($sformatf("%s_ov_clr_r%0d", tag, rs[i]), ov(i), 1'b0);
  endtask

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; in_valid_x = 1'b0; out_ready = 1'b0; out_ready_x = 1'b0;
    decrypt = 1'b0; key = '0; data_in = '0;
    step();
    step();
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk64("rst_data_out", data_out, 64'h0);
    rst = 1'b0;
    #1;
    chk1("post_rst_in_ready", in_ready, 1'b1);

    // Back-to-back encrypt then decrypt, key scrambled while each is in flight
    run_one("enc1", K1, PT, 1'b0, CT);
    run_one("dec1", K1, CT, 1'b1, PT);

    run_all("enc2", K2, P2, 1'b0, 64'h0);
    run_all("dec2", K2, 64'h0, 1'b1, P2);

    // Backpressure: a pending decrypt block is presented throughout ROUND and DONE
    key = K1; data_in = PT; decrypt = 1'b0; in_valid = 1'b1;
    step();
    data_in = CT; decrypt = 1'b1;
    repeat (16) step();
    chk1("bp_ov", out_valid, 1'b1);
    chk64("bp_data", data_out, CT);
    for (int i = 0; i < 10; i++) begin
      step();
      chk1($sformatf("bp_hold_ov%0d", i), out_valid, 1'b1);
      chk64($sformatf("bp_hold_data%0d", i), data_out, CT);
      chk1($sformatf("bp_hold_rdy%0d", i), in_ready, 1'b0);
      chk1($sformatf("bp_hold_busy%0d", i), busy, 1'b1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk1("bp_release_ov", out_valid, 1'b0);
    chk1("bp_release_rdy", in_ready, 1'b1);
    chk1("bp_release_busy", busy, 1'b0);
    step();
    in_valid = 1'b0; key = ~K1; data_in = '0; decrypt = 1'b0;
    chk1("bp_second_busy", busy, 1'b1);
    lat = 1;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    chki("bp_second_latency", lat, 17);
    chk64("bp_second_data", data_out, PT);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset in ROUND cycle 8 discards the block
    key = K1; data_in = PT; decrypt = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    chk1("mid_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk1("mid_rst_in_ready", in_ready, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk1("mid_rst_idle", in_ready, 1'b1);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_ov", out_valid, 1'b0);
    chk64("mid_rst_data", data_out, 64'h0);
    run_one("post_mid_rst", K1, PT, 1'b0, CT);

    // Reset while a result waits in DONE
    key = K2; data_in = P2; decrypt = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (16) step();
    chk1("done_ov", out_valid, 1'b1);
    chk64("done_data", data_out, 64'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk1("done_rst_ov", out_valid, 1'b0);
    chk1("done_rst_idle", in_ready, 1'b1);
    run_one("post_done_rst", K1, CT, 1'b1, PT);
    chk64("post_done_rst_hold", data_out, PT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end
endmodule
